// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// The winner owns the transmitter from its first byte until the byte flagged last.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   uart_transmit,
    output logic [7:0]             uart_tx_byte,
    input  logic                   uart_is_transmitting,
    output logic                   busy,
    output logic                   timeout_error
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [IDX_W-1:0]   winner;
    logic               win_found;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] ready_c;
    logic [7:0]         tx_byte_r, tx_byte_d;
    logic               last_r, last_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic               transmit_d;
    logic               busy_d;
    logic               timeout_d;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    // First valid requester searching upward from rr_ptr with wrap
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!win_found && req_valid[wrap_idx(32'(rr_ptr) + off)]) begin
                winner    = wrap_idx(32'(rr_ptr) + off);
                win_found = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        owner_d   = owner;
        grant_d   = grant;
        tx_byte_d = tx_byte_r;
        last_d    = last_r;
        cnt_d     = cnt;
        ready_c   = '0;
        timeout_d = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    ready_c[winner] = 1'b1;
                    owner_d         = winner;
                    grant_d         = NUM_REQ'(1) << winner;
                    tx_byte_d       = req_data[{winner, 3'b000} +: 8];
                    last_d          = req_last[winner];
                    cnt_d           = '0;
                    state_d         = START;
                end
            end
            START: begin
                if (uart_is_transmitting) begin
                    state_d = DRAIN;
                end else if (cnt_inc == CNT_W'(START_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    rr_ptr_d  = wrap_idx(32'(owner) + 32'd1);
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DRAIN: begin
                if (!uart_is_transmitting) begin
                    if (last_r) begin
                        grant_d  = '0;
                        rr_ptr_d = wrap_idx(32'(owner) + 32'd1);
                        state_d  = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the owner may continue; everyone else waits for release
                if (req_valid[owner]) begin
                    ready_c[owner] = 1'b1;
                    tx_byte_d      = req_data[{owner, 3'b000} +: 8];
                    last_d         = req_last[owner];
                    cnt_d          = '0;
                    state_d        = START;
                end
            end
            default: state_d = IDLE;
        endcase

        transmit_d = (state_d == START);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            grant         <= '0;
            tx_byte_r     <= '0;
            last_r        <= 1'b0;
            cnt           <= '0;
            uart_transmit <= 1'b0;
            busy          <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state         <= state_d;
            rr_ptr        <= rr_ptr_d;
            owner         <= owner_d;
            grant         <= grant_d;
            tx_byte_r     <= tx_byte_d;
            last_r        <= last_d;
            cnt           <= cnt_d;
            uart_transmit <= transmit_d;
            busy          <= busy_d;
            timeout_error <= timeout_d;
        end
    end

    assign uart_tx_byte = tx_byte_r;
    assign req_ready    = rst ? ready_c : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a simple UART responder and a
// message-level round-robin model that predicts the byte stream and its owners.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            uart_transmit;
    logic [7:0]      uart_tx_byte;
    logic            uart_is_transmitting;
    logic            busy;
    logic            timeout_error;

    uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(TO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_last             (req_last),
        .req_ready            (req_ready),
        .grant                (grant),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .busy                 (busy),
        .timeout_error        (timeout_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0]    q  [NR][$];
    logic [8:0]    mq [NR][$];
    logic [NR+7:0] sent_q[$];
    logic [NR+7:0] exp_q[$];
    int            model_ptr = 0;
    bit            stall_en  = 1'b0;
    bit            respond   = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [7:0] b, input logic last, input bit to_model);
        q[i].push_back({last, b});
        if (to_model) mq[i].push_back({last, b});
    endtask

    // Whole messages leave in round-robin order of requesters that have one pending
    function automatic void predict();
        int         w;
        int         i;
        logic [8:0] e;
        w = 0;
        while (w >= 0) begin
            w = -1;
            for (int k = 0; k < int'(NR); k++) begin
                i = (model_ptr + k) % int'(NR);
                if (w < 0 && mq[i].size() > 0) w = i;
            end
            if (w >= 0) begin
                while (mq[w].size() > 0) begin
                    e = mq[w].pop_front();
                    exp_q.push_back({NR'(1) << w, e[7:0]});
                    if (e[8]) break;
                end
                model_ptr = (w + 1) % int'(NR);
            end
        end
    endfunction

    function automatic bit queues_empty();
        bit r;
        r = 1'b1;
        for (int i = 0; i < int'(NR); i++) if (q[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input int max_cycles, input string tag);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
            done = !busy && !uart_transmit && !uart_is_transmitting && queues_empty();
        end
        if (!done) check(tag, 32'd0, 32'd1);
    endtask

    task automatic compare_sent(input string tag);
        check({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < sent_q.size() && k < exp_q.size(); k++) begin
            check({tag, "_byte"},  32'(sent_q[k][7:0]),    32'(exp_q[k][7:0]));
            check({tag, "_owner"}, 32'(sent_q[k][NR+7:8]), 32'(exp_q[k][NR+7:8]));
        end
        sent_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},    32'(grant),         32'd0);
        check({tag, "_transmit"}, 32'(uart_transmit), 32'd0);
        check({tag, "_byte"},     32'(uart_tx_byte),  32'd0);
        check({tag, "_busy"},     32'(busy),          32'd0);
        check({tag, "_timeout"},  32'(timeout_error), 32'd0);
        check({tag, "_ready"},    32'(req_ready),     32'd0);
    endtask

    // Requesters: present the head of their queue; an owner may stall between bytes
    initial begin : driver
        logic       acc_pend;
        int         acc_idx;
        logic [7:0] acc_byte;
        acc_pend  = 1'b0;
        acc_idx   = 0;
        acc_byte  = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (acc_pend) begin
                check("acc_grant",    32'(grant),         32'(NR'(1) << acc_idx));
                check("acc_transmit", 32'(uart_transmit), 32'd1);
                check("acc_busy",     32'(busy),          32'd1);
                check("acc_byte",     32'(uart_tx_byte),  32'(acc_byte));
                acc_pend = 1'b0;
            end
            for (int i = 0; i < int'(NR); i++) begin
                if (q[i].size() > 0) begin
                    req_valid[i]       = (stall_en && grant[i]) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    req_data[8*i +: 8] = q[i][0][7:0];
                    req_last[i]        = q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            #4;
            if (req_ready != '0) begin
                check("ready_onehot",    32'($onehot(req_ready)),                 32'd1);
                check("ready_valid",     32'(req_ready & ~req_valid),             32'd0);
                check("ready_uart_idle", 32'(uart_transmit | uart_is_transmitting), 32'd0);
                if (grant != '0) check("ready_owner", 32'(req_ready), 32'(grant));
            end
            for (int i = 0; i < int'(NR); i++) begin
                if (req_valid[i] && req_ready[i] && q[i].size() > 0) begin
                    acc_pend = 1'b1;
                    acc_idx  = i;
                    acc_byte = q[i][0][7:0];
                    void'(q[i].pop_front());
                end
            end
        end
    end

    // UART: is_transmitting rises once transmit has been seen for 3 cycles, stays 20
    initial begin : uart_model
        int hi;
        int run;
        int hold;
        bit captured;
        hi       = 0;
        run      = 0;
        hold     = 0;
        captured = 1'b0;
        uart_is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_transmit) begin
                run++;
            end else if (run > 0) begin
                check("tx_len", 32'(run), captured ? 32'd3 : 32'(TO));
                run      = 0;
                captured = 1'b0;
            end
            if (uart_is_transmitting) begin
                hold--;
                if (hold == 0) uart_is_transmitting = 1'b0;
            end else if (uart_transmit) begin
                hi++;
                if (respond && hi == 3) begin
                    uart_is_transmitting = 1'b1;
                    hold     = 20;
                    hi       = 0;
                    captured = 1'b1;
                    sent_q.push_back({grant, uart_tx_byte});
                end
            end else begin
                hi = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        int  n;
        bit  seen;
        int  nm;
        int  len;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Single byte from requester 0
        load(0, 8'hA5, 1'b1, 1'b1);
        predict();
        wait_idle(200, "single_idle");
        compare_sent("single");
        check("single_grant_clear", 32'(grant), 32'd0);

        // Contention between 1 and 2
        load(1, 8'hB1, 1'b1, 1'b1);
        load(2, 8'hB2, 1'b1, 1'b1);
        predict();
        wait_idle(300, "contend_idle");
        compare_sent("contend");

        // Pointer wraps: 3 goes before 0
        load(0, 8'hC0, 1'b1, 1'b1);
        load(3, 8'hC3, 1'b1, 1'b1);
        predict();
        wait_idle(300, "wrap_idle");
        compare_sent("wrap");

        // Multi-byte lock with a competing requester arriving mid-message
        stall_en = 1'b1;
        load(0, 8'h11, 1'b0, 1'b1);
        load(0, 8'h22, 1'b0, 1'b1);
        load(0, 8'h33, 1'b1, 1'b1);
        predict();
        n = 0;
        while (!grant[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lock_grant", 32'(grant), 32'h1);
        load(3, 8'h44, 1'b1, 1'b1);
        predict();
        wait_idle(600, "lock_idle");
        compare_sent("lock");

        // Start timeout: UART never answers
        respond = 1'b0;
        load(1, 8'h55, 1'b1, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < int'(TO) + 20) begin
            @(negedge clk);
            n++;
            seen = timeout_error;
        end
        check("to_seen",     32'(seen),          32'd1);
        check("to_busy",     32'(busy),          32'd0);
        check("to_transmit", 32'(uart_transmit), 32'd0);
        check("to_grant",    32'(grant),         32'd0);
        check("to_byte",     32'(uart_tx_byte),  32'h55);
        @(negedge clk);
        check("to_pulse", 32'(timeout_error), 32'd0);
        model_ptr = 2;
        respond   = 1'b1;
        load(0, 8'hD0, 1'b1, 1'b1);
        load(2, 8'hD2, 1'b1, 1'b1);
        predict();
        wait_idle(300, "after_to_idle");
        compare_sent("after_to");

        // Reset while draining
        load(1, 8'h66, 1'b1, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            seen = uart_is_transmitting && !uart_transmit && busy;
        end
        check("drain_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            q[i].delete();
            mq[i].delete();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        model_ptr = 0;
        sent_q.delete();
        n = 0;
        while (uart_is_transmitting && n < 40) begin
            @(negedge clk);
            n++;
        end
        load(2, 8'h77, 1'b1, 1'b1);
        predict();
        wait_idle(300, "post_rst_idle");
        compare_sent("post_rst");

        // Random message mixes
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(NR); i++) begin
                nm = int'($urandom_range(0, 2));
                for (int m = 0; m < nm; m++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) load(i, 8'($urandom), b == len - 1, 1'b1);
                end
            end
            predict();
            wait_idle(4000, "rand_idle");
            compare_sent("rand");
            check("rand_grant_clear", 32'(grant), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
